verificar_pin: RTL

//  Consumes the assembled 4-digit PIN packet (pinPac_t) from the PIN-entry stage and checks it

---
 rtl/verificar_pin.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/verificar_pin.sv
// PIN checker: compares a submitted 4-digit BCD PIN against the master and user PINs,
// pulses ok/fail, counts consecutive failures and enforces a tick-timed lockout.
package verificar_pin_pkg;
  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pinPac_t;
endpackage

module verificar_pin
  import verificar_pin_pkg::*;
#(
  parameter int MAX_TRIES  = 3,
  parameter int LOCK_TICKS = 30,
  localparam int FCW = $clog2(MAX_TRIES + 1),
  localparam int LCW = $clog2(LOCK_TICKS + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  pinPac_t        pin_in,
  input  logic           tick,
  input  logic [15:0]    master_pin,
  input  logic [63:0]    user_pins,
  input  logic [3:0]     user_en,
  output logic           pin_ok,
  output logic           pin_master,
  output logic           pin_fail,
  output logic [1:0]     user_idx,
  output logic           lockout,
  output logic [FCW-1:0] fail_count,
  output logic [LCW-1:0] lock_remaining
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPARE = 2'd1;
  localparam logic [1:0] S_RESULT  = 2'd2;
  localparam logic [1:0] S_LOCKED  = 2'd3;

  logic [1:0]     r_state;
  logic           r_status_prev;
  logic [15:0]    r_pin_q;

  logic           w_submit;
  logic [3:0]     w_digit_bad;
  logic           w_any_bad;
  logic           w_master_hit;
  logic [3:0]     w_user_hit;
  logic           w_user_any;
  logic [1:0]     w_user_sel;
  logic [FCW-1:0] w_fail_inc;

  assign w_submit = pin_in.status & ~r_status_prev;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cmp
      assign w_digit_bad[gi] = (r_pin_q[4*gi +: 4] > 4'd9);
      assign w_user_hit[gi]  = user_en[gi] && (user_pins[16*gi +: 16] == r_pin_q);
    end
  endgenerate

  assign w_any_bad    = |w_digit_bad;
  assign w_master_hit = (r_pin_q == master_pin);
  assign w_user_any   = |w_user_hit;
  assign w_fail_inc   = fail_count + FCW'(1);

  // Scan from the top so the lowest matching slot wins.
  always_comb begin
    w_user_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_user_hit[i]) w_user_sel = 2'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_status_prev  <= 1'b0;
      r_pin_q        <= 16'h0000;
      pin_ok         <= 1'b0;
      pin_master     <= 1'b0;
      pin_fail       <= 1'b0;
      user_idx       <= 2'd0;
      lockout        <= 1'b0;
      fail_count     <= '0;
      lock_remaining <= '0;
    end else begin
      r_status_prev <= pin_in.status;
      pin_ok        <= 1'b0;
      pin_master    <= 1'b0;
      pin_fail      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_submit) begin
            r_pin_q <= {pin_in.digit1, pin_in.digit2, pin_in.digit3, pin_in.digit4};
            r_state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          r_state <= S_RESULT;
          if (!w_any_bad && w_master_hit) begin
            pin_ok     <= 1'b1;
            pin_master <= 1'b1;
            fail_count <= '0;
          end else if (!w_any_bad && w_user_any) begin
            pin_ok     <= 1'b1;
            user_idx   <= w_user_sel;
            fail_count <= '0;
          end else begin
            pin_fail   <= 1'b1;
            fail_count <= w_fail_inc;
            if (w_fail_inc == FCW'(MAX_TRIES)) begin
              lockout        <= 1'b1;
              lock_remaining <= LCW'(LOCK_TICKS);
            end
          end
        end
        S_RESULT: begin
          r_state <= lockout ? S_LOCKED : S_IDLE;
        end
        default: begin
          // Locked: only ticks matter; the last tick releases straight to idle.
          if (tick) begin
            if (lock_remaining <= LCW'(1)) begin
              lock_remaining <= '0;
              lockout        <= 1'b0;
              fail_count     <= '0;
              r_state        <= S_IDLE;
            end else begin
              lock_remaining <= lock_remaining - LCW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule
